output_arbiter: RTL and testbench

// Per-output-port packet scheduler sitting directly downstream of the NUM_PORTS input fifo instances.

---
 rtl/output_arbiter_pkg.sv | 24 ++
 rtl/output_arbiter_rr.sv | 32 +++
 rtl/output_arbiter.sv | 138 +++++++++++++
 tb/tb_output_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared constants, header field positions and FSM state type for the output arbiter.
package output_arbiter_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_WIDTH = 16;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam int REM_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Total beats of a packet: header plus LEN payload beats.
  function automatic logic [REM_W-1:0] pkt_beats(input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len);
    return {1'b0, len} + 7'd1;
  endfunction

endpackage

// File: rtl/output_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  // Scan outward from ptr; the first hit wins.
  always_comb begin
    int idx_s;
    idx_s   = 0;
    gnt     = {N{1'b0}};
    gnt_idx = {IW{1'b0}};
    any_gnt = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx_s = (int'(ptr) + off) % N;
      if (!any_gnt && req[idx_s]) begin
        any_gnt       = 1'b1;
        gnt[idx_s]    = 1'b1;
        gnt_idx       = IW'(idx_s);
      end else begin
        any_gnt = any_gnt;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port packet scheduler: claims fifos whose head targets PORT_ID,
// grants one round-robin and streams the whole packet before re-arbitrating.
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int HDR_W      = DATA_WIDTH >> 1,
  localparam int IW        = $clog2(NUM_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  fifo_empty,
  input  logic [NUM_PORTS-1:0][HDR_W-1:0]       header_in,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  data_in,
  output logic [NUM_PORTS-1:0]                  rd_en,
  input  logic                                  out_ready,
  output logic                                  out_valid,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic [IW-1:0]                         grant_id
);

  localparam logic [1:0] PORT_DEST = 2'(PORT_ID);

  arb_state_t           state_r, next_state_s;
  logic [IW-1:0]        rr_ptr_r, grant_id_r, next_ptr_s;
  logic [REM_W-1:0]     remaining_r;
  logic                 out_valid_r, out_last_r;
  logic [NUM_PORTS-1:0] req_s, gnt_s;
  logic [IW-1:0]        gnt_idx_s;
  logic                 any_gnt_s;
  logic [HDR_W-1:0]     hdr_sel_s;
  logic                 rd_issue_s;

  // Request vector from each fifo's head header.
  always_comb begin
    req_s = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_s[i] = !fifo_empty[i] && (header_in[i][HDR_DEST_MSB:HDR_DEST_LSB] == PORT_DEST);
    end
  end

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
    .req     (req_s),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any_gnt (any_gnt_s)
  );

  // One-hot select of the winning header for the length latch.
  always_comb begin
    hdr_sel_s = {HDR_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_s[i]) begin
        hdr_sel_s = hdr_sel_s | header_in[i];
      end else begin
        hdr_sel_s = hdr_sel_s;
      end
    end
  end

  assign rd_issue_s = (state_r == XFER) && out_ready && !fifo_empty[grant_id_r];
  assign next_ptr_s = (grant_id_r == IW'(NUM_PORTS - 1)) ? {IW{1'b0}} : grant_id_r + IW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = any_gnt_s ? XFER : IDLE;
      XFER:    next_state_s = (rd_issue_s && remaining_r == 7'd1) ? IDLE : XFER;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: read strobe toward the granted fifo only while transferring.
  always_comb begin
    rd_en = {NUM_PORTS{1'b0}};
    busy  = 1'b0;
    case (state_r)
      XFER: begin
        busy              = 1'b1;
        rd_en[grant_id_r] = rd_issue_s;
      end
      IDLE:    busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  // Grant latch, beat counter, round-robin pointer and registered beat qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= {IW{1'b0}};
      grant_id_r  <= {IW{1'b0}};
      remaining_r <= 7'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= rd_issue_s;
      out_last_r  <= rd_issue_s && (remaining_r == 7'd1);
      if (state_r == IDLE && any_gnt_s) begin
        grant_id_r  <= gnt_idx_s;
        remaining_r <= pkt_beats(hdr_sel_s[HDR_LEN_MSB:HDR_LEN_LSB]);
      end else if (rd_issue_s && remaining_r != 7'd0) begin
        remaining_r <= remaining_r - 7'd1;
        if (remaining_r == 7'd1) begin
          rr_ptr_r <= next_ptr_s;
        end
      end
    end
  end

  // Fifo data_out lags rd_en by one cycle, so it lines up with out_valid_r.
  always_comb begin
    if (out_valid_r) begin
      out_data = data_in[grant_id_r];
    end else begin
      out_data = {DATA_WIDTH{1'b0}};
    end
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_output_arbiter.sv
// Randomized scoreboard bench for output_arbiter with a queue-based fifo and scheduling model.
module tb_output_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int DEPTH = 1024;

  logic                   clk;
  logic                   rst_n;
  logic [NP-1:0]          fifo_empty;
  logic [NP-1:0][7:0]     header_in;
  logic [NP-1:0][DW-1:0]  data_in;
  logic [NP-1:0]          rd_en;
  logic                   out_ready;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic                   out_last;
  logic                   busy;
  logic [1:0]             grant_id;

  output_arbiter #(.PORT_ID(0), .NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .header_in(header_in),
    .data_in(data_in), .rd_en(rd_en), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic [1:0]    id;
  } exp_t;

  int checks = 0;
  int fails  = 0;
  int beats_seen = 0;

  exp_t          expq[$];
  logic [DW-1:0] mq[NP][$];
  logic [DW-1:0] pend[NP][$];
  int            mptr = 0;

  logic [DW-1:0] mem[NP][DEPTH];
  int            wr_ptr[NP];
  int            rd_ptr[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Fifo model: registered data_out, header_out and empty reflect the post-read head.
  always @(posedge clk or negedge rst_n) begin
    int r;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        rd_ptr[i]     <= wr_ptr[i];
        data_in[i]    <= '0;
        fifo_empty[i] <= 1'b1;
        header_in[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        r = rd_ptr[i];
        if (rd_en[i] && r != wr_ptr[i]) begin
          data_in[i] <= mem[i][r % DEPTH];
          r++;
        end
        rd_ptr[i]     <= r;
        fifo_empty[i] <= (r == wr_ptr[i]);
        header_in[i]  <= (r == wr_ptr[i]) ? 8'h00 : mem[i][r % DEPTH][7:0];
      end
    end
  end

  // Monitor: pops the scoreboard on every presented beat and checks strobe rules.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("rd_en_onehot", 32'(((rd_en & (rd_en - 4'd1)) != 4'd0)), 32'd0);
      if (!out_ready) chk("rd_en_while_not_ready", 32'(rd_en), 32'd0);
      if ((rd_en & fifo_empty) != 4'd0) chk("rd_en_on_empty", 32'(rd_en & fifo_empty), 32'd0);
      if (out_valid) begin
        beats_seen++;
        if (expq.size() == 0) begin
          chk("unexpected_beat", 32'({out_data, out_last, grant_id}), 32'hFFFFFFFF);
        end else begin
          e = expq.pop_front();
          chk("beat{data,last,id}", 32'({out_data, out_last, grant_id}), 32'({e.d, e.last, e.id}));
        end
      end else if (out_last) begin
        chk("last_without_valid", 32'(out_last), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mem(input int p, input logic [DW-1:0] d);
    mem[p][wr_ptr[p] % DEPTH] = d;
    wr_ptr[p] = wr_ptr[p] + 1;
  endtask

  task automatic push_pkt(input int p, input int len, input int dest, input int nvis);
    logic [DW-1:0] b;
    int n;
    n = len + 1;
    if (nvis < 0) nvis = n;
    for (int k = 0; k < n; k++) begin
      if (k == 0) b = {8'($urandom), 6'(len), 2'(dest)};
      else        b = 16'($urandom);
      if (k < nvis) write_mem(p, b);
      else          pend[p].push_back(b);
      if (dest == 0) mq[p].push_back(b);
    end
  endtask

  task automatic refill(input int p);
    while (pend[p].size() != 0) write_mem(p, pend[p].pop_front());
  endtask

  // Reference scheduler: serve whole packets, first non-empty fifo at/after the pointer.
  task automatic schedule();
    int found;
    int n;
    logic [DW-1:0] h;
    exp_t e;
    while (1) begin
      found = -1;
      for (int k = 0; k < NP; k++) begin
        if (found < 0 && mq[(mptr + k) % NP].size() > 0) found = (mptr + k) % NP;
      end
      if (found < 0) break;
      h = mq[found][0];
      n = int'(h[7:2]) + 1;
      for (int k = 0; k < n; k++) begin
        e.d = mq[found].pop_front();
        e.last = (k == n - 1);
        e.id = 2'(found);
        expq.push_back(e);
      end
      mptr = (found + 1) % NP;
    end
  endtask

  task automatic wait_busy(input int limit);
    int c;
    c = 0;
    while (!busy && c < limit) begin
      tick(1);
      c++;
    end
    chk("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int limit, input bit rnd);
    int c;
    c = 0;
    while ((expq.size() != 0 || busy) && c < limit) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      c++;
    end
    out_ready = 1'b1;
    chk("drain_left", 32'(expq.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_grant_id",  32'(grant_id),  32'd0);
    chk("rst_rd_en",     32'(rd_en),     32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    expq.delete();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      pend[i].delete();
    end
    mptr = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int base;
    int c;
    for (int i = 0; i < NP; i++) wr_ptr[i] = 0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Round-robin fairness: 0,1,3 then pointer back to 0.
    push_pkt(0, 0, 0, -1);
    push_pkt(1, 0, 0, -1);
    push_pkt(3, 0, 0, -1);
    schedule();
    drain(200, 1'b0);
    push_pkt(1, 0, 0, -1);
    push_pkt(0, 0, 0, -1);
    schedule();
    drain(200, 1'b0);

    // Single packet, header 0x0C from fifo 2: four consecutive reads.
    write_mem(2, 16'hA50C);
    mq[2].push_back(16'hA50C);
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] d;
      d = 16'h1110 + 16'(k);
      write_mem(2, d);
      mq[2].push_back(d);
    end
    schedule();
    wait_busy(20);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("single_rd_en", 32'(rd_en), 32'h4);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("single_rd_en_after", 32'(rd_en), 32'h0);
    @(posedge clk);
    #1;
    drain(200, 1'b0);

    // Backpressure: LEN=5, ready dropped for two cycles mid-packet.
    base = beats_seen;
    push_pkt(1, 5, 0, -1);
    schedule();
    wait_busy(20);
    tick(1);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_rd_en", 32'(rd_en), 32'h0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain(200, 1'b0);
    chk("bp_beats", 32'(beats_seen - base), 32'd6);

    // Underflow stall: only 2 of 4 beats present at first.
    base = beats_seen;
    push_pkt(3, 3, 0, 2);
    schedule();
    wait_busy(20);
    tick(8);
    @(negedge clk);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_rd_en", 32'(rd_en), 32'h0);
    chk("stall_beats", 32'(beats_seen - base), 32'd2);
    @(posedge clk);
    #1;
    refill(3);
    drain(200, 1'b0);
    chk("stall_total", 32'(beats_seen - base), 32'd4);

    // Destination filter: a head for port 2 is never claimed.
    push_pkt(1, 2, 2, -1);
    for (int k = 0; k < 4; k++) begin
      tick(5);
      @(negedge clk);
      chk("filter_rd_en", 32'(rd_en), 32'h0);
      chk("filter_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end
    do_reset();

    // Reset mid-packet: move pointer to 2, then abort a LEN=7 packet from fifo 2.
    push_pkt(1, 0, 0, -1);
    schedule();
    drain(200, 1'b0);
    push_pkt(2, 7, 0, -1);
    schedule();
    base = beats_seen;
    c = 0;
    while (beats_seen < base + 2 && c < 50) begin
      tick(1);
      c++;
    end
    chk("mid_beats_before_reset", 32'(beats_seen - base), 32'd2);
    do_reset();
    push_pkt(3, 0, 0, -1);
    push_pkt(0, 0, 0, -1);
    schedule();
    drain(200, 1'b0);

    // Randomized batches with random backpressure.
    for (int b = 0; b < 40; b++) begin
      int npk;
      npk = $urandom_range(1, 4);
      for (int k = 0; k < npk; k++) begin
        int p;
        int len;
        p = $urandom_range(0, NP - 1);
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
        push_pkt(p, len, 0, -1);
      end
      schedule();
      drain(4000, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
